// File: rtl/prot_accum_responder.sv
// Accumulating responder. Every cycle with in_valid high is a sample. An accepted sample
// adds accum_in into a wrapping accumulator, bumps a saturating sample counter, and loads
// a set of pass-through payload registers of assorted widths. A sticky flag records any
// carry out of the accumulator. A two-state machine (IDLE/RUN) tracks whether anything
// has been accepted since the last clear.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clear                synchronous restart of accumulator, counter, flag and state
//   in_valid             current inputs form a sample (no backpressure)
//   accum_in             addend
//   s*_in                echo payloads (1/2/8/33/64/65/129 bits)
//   out_valid            in_valid delayed by one cycle
//   accum_out            running sum modulo 2^ACC_W
//   s*_out               registered payload echoes
//   sample_cnt           accepted-sample count, saturating
//   wrap_flag            sticky accumulator-carry flag
//   state                0 = IDLE, 1 = RUN
module prot_accum_responder #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] accum_in,
  input  logic             s1_in,
  input  logic [1:0]       s2_in,
  input  logic [7:0]       s8_in,
  input  logic [32:0]      s33_in,
  input  logic [63:0]      s64_in,
  input  logic [64:0]      s65_in,
  input  logic [128:0]     s129_in,
  output logic             out_valid,
  output logic [ACC_W-1:0] accum_out,
  output logic             s1_out,
  output logic [1:0]       s2_out,
  output logic [7:0]       s8_out,
  output logic [32:0]      s33_out,
  output logic [63:0]      s64_out,
  output logic [64:0]      s65_out,
  output logic [128:0]     s129_out,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             wrap_flag,
  output logic             state
);

  typedef enum logic {StIdle = 1'b0, StRun = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic               valid_q;
  logic [ACC_W:0]     sum;

  logic               s1_q;
  logic [1:0]         s2_q;
  logic [7:0]         s8_q;
  logic [32:0]        s33_q;
  logic [63:0]        s64_q;
  logic [64:0]        s65_q;
  logic [128:0]       s129_q;

  // Extra top bit captures the carry out of the accumulator.
  assign sum = {1'b0, acc_q} + {1'b0, accum_in};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    if (clear && in_valid) begin
      // Restart with this sample as the first one; its addition cannot wrap.
      acc_d   = accum_in;
      cnt_d   = CNT_W'(1);
      wrap_d  = 1'b0;
      state_d = StRun;
    end else if (clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      wrap_d  = 1'b0;
      state_d = StIdle;
    end else if (in_valid) begin
      acc_d   = sum[ACC_W-1:0];
      wrap_d  = wrap_q | sum[ACC_W];
      state_d = StRun;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      valid_q <= in_valid;
    end
  end

  // Payload echoes load on every accepted sample, clear or not, and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s8_q   <= '0;
      s33_q  <= '0;
      s64_q  <= '0;
      s65_q  <= '0;
      s129_q <= '0;
    end else if (in_valid) begin
      s1_q   <= s1_in;
      s2_q   <= s2_in;
      s8_q   <= s8_in;
      s33_q  <= s33_in;
      s64_q  <= s64_in;
      s65_q  <= s65_in;
      s129_q <= s129_in;
    end
  end

  assign out_valid  = valid_q;
  assign accum_out  = acc_q;
  assign sample_cnt = cnt_q;
  assign wrap_flag  = wrap_q;
  assign state      = state_q;
  assign s1_out     = s1_q;
  assign s2_out     = s2_q;
  assign s8_out     = s8_q;
  assign s33_out    = s33_q;
  assign s64_out    = s64_q;
  assign s65_out    = s65_q;
  assign s129_out   = s129_q;

endmodule

// File: tb/tb_prot_accum_responder.sv
// Scoreboard bench for prot_accum_responder. A default instance (CNT_W = 16) and a
// CNT_W = 4 instance share all inputs; the second one exercises counter saturation.
module tb_prot_accum_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  accum_in = '0;
  logic         s1_in = '0;
  logic [1:0]   s2_in = '0;
  logic [7:0]   s8_in = '0;
  logic [32:0]  s33_in = '0;
  logic [63:0]  s64_in = '0;
  logic [64:0]  s65_in = '0;
  logic [128:0] s129_in = '0;

  logic         out_valid, s1_out, wrap_flag, state;
  logic [31:0]  accum_out;
  logic [1:0]   s2_out;
  logic [7:0]   s8_out;
  logic [32:0]  s33_out;
  logic [63:0]  s64_out;
  logic [64:0]  s65_out;
  logic [128:0] s129_out;
  logic [15:0]  sample_cnt;

  logic         d2_out_valid, d2_s1_out, d2_wrap_flag, d2_state;
  logic [31:0]  d2_accum_out;
  logic [1:0]   d2_s2_out;
  logic [7:0]   d2_s8_out;
  logic [32:0]  d2_s33_out;
  logic [63:0]  d2_s64_out;
  logic [64:0]  d2_s65_out;
  logic [128:0] d2_s129_out;
  logic [3:0]   d2_sample_cnt;

  always #5 clk = ~clk;

  prot_accum_responder #(.ACC_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .accum_in(accum_in),
    .s1_in(s1_in), .s2_in(s2_in), .s8_in(s8_in), .s33_in(s33_in), .s64_in(s64_in),
    .s65_in(s65_in), .s129_in(s129_in), .out_valid(out_valid), .accum_out(accum_out),
    .s1_out(s1_out), .s2_out(s2_out), .s8_out(s8_out), .s33_out(s33_out),
    .s64_out(s64_out), .s65_out(s65_out), .s129_out(s129_out), .sample_cnt(sample_cnt),
    .wrap_flag(wrap_flag), .state(state)
  );

  prot_accum_responder #(.ACC_W(32), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .accum_in(accum_in),
    .s1_in(s1_in), .s2_in(s2_in), .s8_in(s8_in), .s33_in(s33_in), .s64_in(s64_in),
    .s65_in(s65_in), .s129_in(s129_in), .out_valid(d2_out_valid), .accum_out(d2_accum_out),
    .s1_out(d2_s1_out), .s2_out(d2_s2_out), .s8_out(d2_s8_out), .s33_out(d2_s33_out),
    .s64_out(d2_s64_out), .s65_out(d2_s65_out), .s129_out(d2_s129_out),
    .sample_cnt(d2_sample_cnt), .wrap_flag(d2_wrap_flag), .state(d2_state)
  );

  typedef struct {
    logic [31:0]  acc;
    logic [15:0]  cnt;
    logic [3:0]   cnt4;
    logic         wrap;
    logic         st;
    logic         ov;
    logic         s1;
    logic [1:0]   s2;
    logic [7:0]   s8;
    logic [32:0]  s33;
    logic [63:0]  s64;
    logic [64:0]  s65;
    logic [128:0] s129;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;  // reference model state

  int n_checks = 0;
  int n_fail   = 0;

  // Payload values the next cycle will drive.
  logic         p_s1;
  logic [1:0]   p_s2;
  logic [7:0]   p_s8;
  logic [32:0]  p_s33;
  logic [63:0]  p_s64;
  logic [64:0]  p_s65;
  logic [128:0] p_s129;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_payload();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    p_s1   = r[0];
    p_s2   = r[2:1];
    p_s8   = r[10:3];
    p_s33  = r[43:11];
    p_s64  = r[127:64];
    p_s65  = r[64:0];
    p_s129 = r[128:0];
  endtask

  task automatic reset_model();
    m = '{acc: '0, cnt: '0, cnt4: '0, wrap: 1'b0, st: 1'b0, ov: 1'b0, s1: '0, s2: '0,
          s8: '0, s33: '0, s64: '0, s65: '0, s129: '0};
    sb_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".ov"},    256'(out_valid),  '0);
    check_eq({tag, ".acc"},   256'(accum_out),  '0);
    check_eq({tag, ".cnt"},   256'(sample_cnt), '0);
    check_eq({tag, ".wrap"},  256'(wrap_flag),  '0);
    check_eq({tag, ".state"}, 256'(state),      '0);
    check_eq({tag, ".s129"},  256'(s129_out),   '0);
    check_eq({tag, ".s65"},   256'(s65_out),    '0);
    check_eq({tag, ".s1"},    256'(s1_out),     '0);
    check_eq({tag, ".cnt4"},  256'(d2_sample_cnt), '0);
  endtask

  // Drive one cycle of stimulus, advance the model, push its prediction, then compare the
  // DUT outputs just after the edge against the popped prediction.
  task automatic cyc(input string tag, input logic clr, input logic v, input logic [31:0] a);
    exp_t e;
    logic [32:0] t;
    clear = clr; in_valid = v; accum_in = a;
    s1_in = p_s1; s2_in = p_s2; s8_in = p_s8; s33_in = p_s33;
    s64_in = p_s64; s65_in = p_s65; s129_in = p_s129;
    if (clr && v) begin
      m.acc = a; m.cnt = 16'd1; m.cnt4 = 4'd1; m.wrap = 1'b0; m.st = 1'b1;
    end else if (clr) begin
      m.acc = '0; m.cnt = '0; m.cnt4 = '0; m.wrap = 1'b0; m.st = 1'b0;
    end else if (v) begin
      t = {1'b0, m.acc} + {1'b0, a};
      m.acc = t[31:0];
      if (t[32]) m.wrap = 1'b1;
      if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
      if (m.cnt4 != 4'hF) m.cnt4 = m.cnt4 + 4'd1;
      m.st = 1'b1;
    end
    if (v) begin
      m.s1 = p_s1; m.s2 = p_s2; m.s8 = p_s8; m.s33 = p_s33;
      m.s64 = p_s64; m.s65 = p_s65; m.s129 = p_s129;
    end
    m.ov = v;
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 256'(1), 256'(0));
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, ".ov"},    256'(out_valid),     256'(e.ov));
      check_eq({tag, ".acc"},   256'(accum_out),     256'(e.acc));
      check_eq({tag, ".cnt"},   256'(sample_cnt),    256'(e.cnt));
      check_eq({tag, ".wrap"},  256'(wrap_flag),     256'(e.wrap));
      check_eq({tag, ".state"}, 256'(state),         256'(e.st));
      check_eq({tag, ".s1"},    256'(s1_out),        256'(e.s1));
      check_eq({tag, ".s2"},    256'(s2_out),        256'(e.s2));
      check_eq({tag, ".s8"},    256'(s8_out),        256'(e.s8));
      check_eq({tag, ".s33"},   256'(s33_out),       256'(e.s33));
      check_eq({tag, ".s64"},   256'(s64_out),       256'(e.s64));
      check_eq({tag, ".s65"},   256'(s65_out),       256'(e.s65));
      check_eq({tag, ".s129"},  256'(s129_out),      256'(e.s129));
      check_eq({tag, ".cnt4"},  256'(d2_sample_cnt), 256'(e.cnt4));
      check_eq({tag, ".acc4"},  256'(d2_accum_out),  256'(e.acc));
    end
  endtask

  initial begin
    logic [31:0]  sum40;
    logic [31:0]  a;
    logic [128:0] pat129;
    reset_model();
    rand_payload();

    // Reset held: outputs zero regardless of clock activity.
    #1;
    check_zero("rst_hold0");
    @(posedge clk); #1;
    check_zero("rst_hold1");
    @(negedge clk);
    rst_n = 1'b1;

    // Three samples straight after reset release.
    cyc("acc0", 1'b0, 1'b1, 32'd0);
    cyc("acc5", 1'b0, 1'b1, 32'd5);
    cyc("acc10", 1'b0, 1'b1, 32'd10);
    check_eq("seq_sum", 256'(accum_out), 256'(32'd15));
    check_eq("seq_cnt", 256'(sample_cnt), 256'(16'd3));
    check_eq("seq_state", 256'(state), 256'(1));
    cyc("idle0", 1'b0, 1'b0, 32'hDEAD);

    // Wrap: load 0xFFFFFFF0 via clear+valid, then carry out.
    cyc("ld_fff0", 1'b1, 1'b1, 32'hFFFF_FFF0);
    cyc("wrap", 1'b0, 1'b1, 32'h20);
    check_eq("wrap_acc", 256'(accum_out), 256'(32'h10));
    check_eq("wrap_flag", 256'(wrap_flag), 256'(1));
    cyc("wrap_stick", 1'b0, 1'b1, 32'd1);
    check_eq("stick_acc", 256'(accum_out), 256'(32'h11));
    check_eq("stick_flag", 256'(wrap_flag), 256'(1));

    // Wide payload echoes, then hold across an idle cycle with different inputs.
    pat129 = {1'b1, {16{8'hA5}}};
    p_s129 = pat129;
    p_s65  = 65'h1_0000_0000_0000_0001;
    p_s1   = 1'b1;
    cyc("pay_ld", 1'b0, 1'b1, 32'd0);
    rand_payload();
    p_s1 = 1'b0;
    cyc("pay_hold", 1'b0, 1'b0, 32'd77);
    check_eq("pay_s129", 256'(s129_out), 256'(pat129));
    check_eq("pay_s65", 256'(s65_out), 256'(65'h1_0000_0000_0000_0001));
    check_eq("pay_s1", 256'(s1_out), 256'(1));

    // Clear together with valid: no wrap even though the old sum would carry.
    cyc("to_max", 1'b1, 1'b1, 32'hFFFF_FFFF);
    cyc("clrv_nowrap", 1'b1, 1'b1, 32'd5);
    check_eq("clrv_wrap", 256'(wrap_flag), 256'(0));
    cyc("to50", 1'b1, 1'b1, 32'd50);
    cyc("to100", 1'b0, 1'b1, 32'd50);
    cyc("clrv7", 1'b1, 1'b1, 32'd7);
    check_eq("clrv7_acc", 256'(accum_out), 256'(32'd7));
    check_eq("clrv7_cnt", 256'(sample_cnt), 256'(16'd1));
    check_eq("clrv7_state", 256'(state), 256'(1));
    rand_payload();
    cyc("clr_only", 1'b1, 1'b0, 32'd9);
    check_eq("clr_acc", 256'(accum_out), 256'(32'd0));
    check_eq("clr_state", 256'(state), 256'(0));
    cyc("clr_idle", 1'b1, 1'b0, 32'd9);
    cyc("idle_hold", 1'b0, 1'b0, 32'd9);

    // Build some state, then pulse reset mid-cycle with a sample pending.
    cyc("pre_rst", 1'b0, 1'b1, 32'd1234);
    in_valid = 1'b1; accum_in = 32'd9;
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    reset_model();
    @(posedge clk); #1;
    check_zero("rst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero("rst_rel");
    cyc("post_rst", 1'b0, 1'b1, 32'd3);
    check_eq("post_rst_acc", 256'(accum_out), 256'(32'd3));
    check_eq("post_rst_cnt", 256'(sample_cnt), 256'(16'd1));

    // Counter saturation on the CNT_W = 4 instance.
    cyc("sat_clr", 1'b1, 1'b0, 32'd0);
    sum40 = '0;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      sum40 = sum40 + a;
      rand_payload();
      cyc($sformatf("sat%0d", i), 1'b0, 1'b1, a);
    end
    check_eq("sat_cnt4", 256'(d2_sample_cnt), 256'(4'd15));
    check_eq("sat_acc4", 256'(d2_accum_out), 256'(sum40));
    check_eq("sat_cnt16", 256'(sample_cnt), 256'(16'd20));

    // Random mix of clear/valid.
    for (int i = 0; i < 40; i++) begin
      rand_payload();
      cyc($sformatf("mix%0d", i), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
          $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prot_accum_responder.md
PROT_ACCUM_RESPONDER -- requirements
Module: prot_accum_responder

Interface
REQ-001 The block SHALL have parameter ACC_W, default 32, giving the accumulator width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the sample counter width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous restart of the accumulator, counter and flag.
REQ-007 in_valid  input  1  the current cycle's inputs are a sample.
REQ-008 accum_in  input  ACC_W  addend.
REQ-009 s1_in, s2_in, s8_in, s33_in, s64_in, s65_in, s129_in  input  1/2/8/33/64/65/129  echo payloads.
REQ-010 out_valid  output  1  outputs updated by the sample accepted one cycle earlier.
REQ-011 accum_out  output  ACC_W  running sum.
REQ-012 s1_out .. s129_out  output  widths matching s*_in  registered echoes.
REQ-013 sample_cnt  output  CNT_W  number of accepted samples.
REQ-014 wrap_flag  output  1  sticky; set when the accumulator has wrapped.
REQ-015 state  output  1  0 = IDLE, 1 = RUN.

Function
REQ-016 A sample SHALL be accepted on every rising clk edge where in_valid = 1; there is no backpressure.
REQ-017 On acceptance, accum_out SHALL become accum_out + accum_in, modulo 2^ACC_W (1-cycle latency).
REQ-018 On acceptance, each sN_out SHALL load sN_in bit-exactly in the same edge.
REQ-019 Without acceptance, accum_out and all sN_out SHALL hold their values.
REQ-020 out_valid SHALL equal in_valid registered by one cycle, independent of state.
REQ-021 wrap_flag SHALL set on any acceptance whose sum carries out of bit ACC_W-1.
REQ-022 wrap_flag SHALL remain set until clear or reset.
REQ-023 sample_cnt SHALL increment by 1 per acceptance and saturate at 2^CNT_W-1; it never wraps.
REQ-024 The state machine SHALL have two states: IDLE and RUN.
REQ-025 IDLE SHALL go to RUN on the first acceptance.
REQ-026 RUN SHALL go to IDLE on clear without in_valid.
REQ-027 IDLE with clear SHALL stay in IDLE.
REQ-028 clear without in_valid SHALL zero accum_out, sample_cnt and wrap_flag and leave sN_out unchanged.
REQ-029 clear with in_valid in the same cycle SHALL load accum_out with accum_in, set sample_cnt to 1, zero wrap_flag, load sN_out and go to (or stay in) RUN.
REQ-030 An accumulate occurring together with clear SHALL NOT set wrap_flag.
REQ-031 X-free: no output SHALL depend on uninitialised state after reset.

Reset
REQ-032 While rst_n = 0, all outputs SHALL read 0 and state SHALL be IDLE, regardless of clk.
REQ-033 Assertion of rst_n mid-operation SHALL discard any in-flight sample immediately; no partial update is permitted.
REQ-034 After rst_n deasserts, the first rising clk edge SHALL be able to accept a sample.

Verification
REQ-035 After reset, apply in_valid=1 with accum_in = 0, 5, 10 on three consecutive cycles -> accum_out = 0, 5, 15 one cycle after each, sample_cnt = 3, out_valid high three cycles, state = RUN.
REQ-036 With accum_out = 0xFFFFFFF0, accept accum_in = 0x20 -> accum_out = 0x00000010, wrap_flag = 1; then accept accum_in = 1 -> accum_out = 0x11, wrap_flag stays 1.
REQ-037 Accept s129_in = {1'b1, 128'hA5..A5}, s65_in = 65'h1_0000_0000_0000_0001, s1_in = 1; then in_valid = 0 -> outputs match bit-exactly one cycle later and hold through the idle cycle.
REQ-038 With accum_out = 100, apply clear and in_valid together with accum_in = 7 -> accum_out = 7, sample_cnt = 1, wrap_flag = 0, state = RUN; then clear alone -> accum_out = 0, state = IDLE.
REQ-039 Pulse rst_n low between clock edges while in_valid = 1 -> all outputs read 0 asynchronously; after release, accepting accum_in = 3 gives accum_out = 3, sample_cnt = 1.
REQ-040 With CNT_W = 4, accept 20 samples -> sample_cnt saturates at 15 and accum_out equals the sum of all 20 addends.
